tag_alloc_ctrl: RTL and testbench
=================================

Name: tag_alloc_ctrl

Overview:
- Allocates slot tags for a small pool of DW slots and tracks which slots are busy.
- Drives one-hot set/reset request vectors that feed a downstream set/reset flop vector (set_in/rst_in) holding the per-slot valid bits.
- The internal busy vector is the architectural copy; the downstream flop vector mirrors it cycle-exactly.
- Used by testbench and core-side trackers (outstanding-request and ROB-like slot pools).

Parameters:
- DW, 8: number of slots; power of two, 2..64.
- AW, 3: tag width, equal to log2(DW).

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RST, input, 1: synchronous reset, active-high.
- alloc_valid, input, 1: requester wants a tag.
- alloc_ready, output, 1: a free slot exists and no flush is active.
- alloc_tag, output, AW: lowest-index free slot, valid while alloc_ready=1.
- free_valid, input, 1: release request.
- free_tag, input, AW: slot to release.
- flush, input, 1: release all slots.
- busy, output, DW: registered busy vector.
- set_out, output, DW: one-hot set pulse; connect to downstream set_in.
- rst_out, output, DW: reset pulse vector; connect to downstream rst_in.
- cnt, output, AW+1: number of busy slots, 0..DW.
- full, output, 1: cnt==DW.
- empty, output, 1: cnt==0.
- err_dblfree, output, 1: sticky flag for release of a non-busy slot.

Behaviour:
- Reset is synchronous, active-high (RST=1 at a rising edge of CLK):
  - busy=0, cnt=0, empty=1, full=0, err_dblfree=0.
  - set_out=0, rst_out=0, and all request inputs are ignored in that cycle.
- Combinational outputs, from registered state only (no same-cycle free→alloc bypass):
  - alloc_ready = ~full & ~flush.
  - alloc_tag = index of the lowest 0 bit in busy; when full, alloc_tag=0 (don't-care).
- Alloc fire = alloc_valid & alloc_ready:
  - set_out = one-hot(alloc_tag) in the same cycle.
  - busy[alloc_tag]=1 at the next edge (latency 1).
  - When there is no fire, set_out=0.
  - alloc_valid may drop without a fire; no state change.
- Free, when flush=0 and free_valid=1:
  - If busy[free_tag]=1: rst_out = one-hot(free_tag), and busy[free_tag]=0 at the next edge.
  - If busy[free_tag]=0: rst_out=0, busy and cnt unchanged, err_dblfree=1 at the next edge and held until RST.
  - free_tag >= DW cannot occur (DW is a power of two).
- Simultaneous alloc fire and valid free in one cycle:
  - Both take effect; tags always differ because alloc picks a non-busy slot and a valid free targets a busy one.
  - cnt unchanged.
- A freed slot becomes allocatable one cycle after the free (registered). Full with a same-cycle free gives alloc_ready=0 that cycle.
- Flush=1:
  - rst_out = busy; set_out=0; alloc_ready=0; free_valid ignored with no error check.
  - Next edge: busy=0, cnt=0.
- Counter: cnt_next = cnt + fire_alloc − fire_free_valid. It never wraps.
- full and empty are registered, derived from cnt_next.
- Invariants, each checked every cycle:
  - popcount(busy) == cnt.
  - set_out & busy == 0.
  - rst_out & ~busy == 0.
  - A gen_rsffr with rstValue=0, driven by set_out/rst_out and reset in the same cycle as this block, equals busy every cycle.
- Reset mid-operation: pending pulses are dropped. Outputs are in reset state the cycle after RST.

Test Plan:
- Reset, then hold alloc_valid=1 for 8 cycles (DW=8) → alloc_tag 0,1,…,7 in order; set_out 0x01,0x02,…,0x80; cnt 1..8; then full=1, alloc_ready=0; busy=0xFF.
- From full, free_tag=5 → rst_out=0x20; next cycle busy=0xDF, cnt=7, alloc_ready=1, alloc_tag=5.
- busy=0x0F; in one cycle alloc fires (tag 4) and free_tag=1 → set_out=0x10, rst_out=0x02; next busy=0x1D, cnt=4.
- busy=0x03, free_tag=6 → rst_out=0, busy and cnt unchanged, err_dblfree=1 and held through later traffic until RST.
- busy=0xA5, flush=1 with alloc_valid=1 and free_valid=1 → alloc_ready=0, set_out=0, rst_out=0xA5; next busy=0, cnt=0, empty=1.
- Random alloc/free/flush for 10k cycles with RST asserted mid-run → all invariants hold; the mirrored gen_rsffr qout equals busy every cycle; busy=0 the cycle after RST.

Source files
------------

// File: rtl/tag_alloc_ctrl_if.sv
// rtl/tag_alloc_ctrl_if.sv - alloc/free/flush handshake between a requester and the tag allocator
interface tag_alloc_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          alloc_valid;
    logic          alloc_ready;
    logic [AW-1:0] alloc_tag;
    logic          free_valid;
    logic [AW-1:0] free_tag;
    logic          flush;

    modport master (
        output alloc_valid, free_valid, free_tag, flush,
        input  alloc_ready, alloc_tag
    );

    modport slave (
        input  alloc_valid, free_valid, free_tag, flush,
        output alloc_ready, alloc_tag
    );
endinterface

// File: rtl/tag_alloc_ctrl.sv
// rtl/tag_alloc_ctrl.sv - slot tag allocator with busy tracking and set/reset pulses for a mirrored flop vector
module tag_alloc_ctrl #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic                CLK,
    input  logic                RST,
    tag_alloc_ctrl_if.slave     bus,
    output logic [DW-1:0]       busy,
    output logic [DW-1:0]       set_out,
    output logic [DW-1:0]       rst_out,
    output logic [AW:0]         cnt,
    output logic                full,
    output logic                empty,
    output logic                err_dblfree
);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DW);
    localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] busy_q, busy_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q, err_q, err_d;
    logic [AW-1:0] free_slot;
    logic          fire_alloc, fire_free;

    // Lowest-index free slot; stays 0 when every slot is busy.
    always_comb begin
        logic found;
        free_slot = '0;
        found     = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (!found && !busy_q[i]) begin
                free_slot = i[AW-1:0];
                found     = 1'b1;
            end
        end
    end

    assign bus.alloc_ready = ~full_q & ~bus.flush;
    assign bus.alloc_tag   = free_slot;

    assign fire_alloc = bus.alloc_valid & ~full_q & ~bus.flush & ~RST;
    assign fire_free  = bus.free_valid & ~bus.flush & busy_q[bus.free_tag] & ~RST;

    always_comb begin
        set_out = '0;
        rst_out = '0;
        if (!RST) begin
            if (bus.flush) begin
                rst_out = busy_q;
            end else begin
                if (fire_alloc) set_out = ONE << free_slot;
                if (fire_free)  rst_out = ONE << bus.free_tag;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (bus.flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            busy_d = (busy_q | set_out) & ~rst_out;
            cnt_d  = cnt_q + {{AW{1'b0}}, fire_alloc} - {{AW{1'b0}}, fire_free};
            if (bus.free_valid && !busy_q[bus.free_tag]) err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FULL_CNT);
            empty_q <= (cnt_d == '0);
            err_q   <= err_d;
        end
    end

    assign busy        = busy_q;
    assign cnt         = cnt_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign err_dblfree = err_q;
endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// tb/tb_tag_alloc_ctrl.sv - directed and randomized bench for tag_alloc_ctrl against a slot-array model
module tb_tag_alloc_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] busy, set_out, rst_out;
    logic [AW:0]   cnt;
    logic          full, empty, err_dblfree;
    logic [DW-1:0] mirror;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;

    bit mb[DW];
    int mcnt;
    bit merr;

    tag_alloc_ctrl_if #(.DW(DW), .AW(AW)) tif ();

    tag_alloc_ctrl #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .bus(tif.slave),
        .busy(busy), .set_out(set_out), .rst_out(rst_out), .cnt(cnt),
        .full(full), .empty(empty), .err_dblfree(err_dblfree)
    );

    always #5 CLK = ~CLK;

    // Downstream set/reset flop vector, reset together with the DUT.
    always @(posedge CLK) begin
        if (RST) mirror <= '0;
        else     mirror <= (mirror | set_out) & ~rst_out;
    end

    always @(negedge CLK) begin
        #3;
        if (inv_en) begin
            checks++;
            if ($countones(busy) != int'(cnt)) begin
                errors++; $display("FAIL inv_popcount busy=%h cnt=%0d", busy, cnt);
            end
            checks++;
            if ((set_out & busy) !== '0) begin
                errors++; $display("FAIL inv_set_busy set_out=%h busy=%h", set_out, busy);
            end
            checks++;
            if ((rst_out & ~busy) !== '0) begin
                errors++; $display("FAIL inv_rst_busy rst_out=%h busy=%h", rst_out, busy);
            end
            checks++;
            if (mirror !== busy) begin
                errors++; $display("FAIL inv_mirror mirror=%h busy=%h", mirror, busy);
            end
        end
    end

    function automatic logic [DW-1:0] m_vec();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < DW; i++) if (mb[i]) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int m_tag();
        for (int i = 0; i < DW; i++) if (!mb[i]) return i;
        return 0;
    endfunction

    function automatic bit m_ready();
        return (mcnt != DW) && !tif.flush;
    endfunction

    task automatic model_edge();
        int  t;
        bit  fa, ff;
        if (RST) begin
            for (int i = 0; i < DW; i++) mb[i] = 0;
            mcnt = 0; merr = 0;
        end else if (tif.flush) begin
            for (int i = 0; i < DW; i++) mb[i] = 0;
            mcnt = 0;
        end else begin
            t  = m_tag();
            fa = tif.alloc_valid && m_ready();
            ff = tif.free_valid && mb[tif.free_tag];
            if (tif.free_valid && !mb[tif.free_tag]) merr = 1;
            if (fa) begin mb[t] = 1; mcnt++; end
            if (ff) begin mb[tif.free_tag] = 0; mcnt--; end
        end
    endtask

    task automatic drive(input bit av, input bit fv, input int ft, input bit fl);
        tif.alloc_valid = av;
        tif.free_valid  = fv;
        tif.free_tag    = ft[AW-1:0];
        tif.flush       = fl;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        drive(0, 0, 0, 0);
        @(posedge CLK); model_edge();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic do_cycle(input bit av, input bit fv, input int ft, input bit fl);
        drive(av, fv, ft, fl);
        @(posedge CLK); model_edge();
        @(negedge CLK);
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        drive(1, 1, 3, 0);
        #1;
        checks++;
        if (set_out !== '0 || rst_out !== '0) begin
            errors++; $display("FAIL reset_pulses set_out=%h rst_out=%h want 0", set_out, rst_out);
        end
        @(posedge CLK); model_edge(); #1;
        checks++;
        if (busy !== '0 || cnt !== '0 || empty !== 1'b1 || full !== 1'b0 || err_dblfree !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%h cnt=%0d empty=%b full=%b err=%b want 0/0/1/0/0",
                     busy, cnt, empty, full, err_dblfree);
        end
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (tif.alloc_ready !== 1'b1 || tif.alloc_tag !== '0) begin
            errors++; $display("FAIL reset_ready ready=%b tag=%0d want 1/0", tif.alloc_ready, tif.alloc_tag);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DW; i++) begin
            drive(1, 0, 0, 0);
            #1;
            checks++;
            if (tif.alloc_tag !== i[AW-1:0] || set_out !== (8'h01 << i)) begin
                errors++; $display("FAIL fill_tag step=%0d tag=%0d set_out=%h", i, tif.alloc_tag, set_out);
            end
            @(posedge CLK); model_edge(); #1;
            checks++;
            if (int'(cnt) != i + 1) begin
                errors++; $display("FAIL fill_cnt step=%0d cnt=%0d want %0d", i, cnt, i + 1);
            end
            @(negedge CLK);
        end
        drive(1, 0, 0, 0);
        #1;
        checks++;
        if (full !== 1'b1 || tif.alloc_ready !== 1'b0 || busy !== 8'hFF || set_out !== '0) begin
            errors++;
            $display("FAIL fill_full full=%b ready=%b busy=%h set_out=%h want 1/0/ff/00",
                     full, tif.alloc_ready, busy, set_out);
        end
        @(posedge CLK); model_edge();
        @(negedge CLK);
        drive(0, 0, 0, 0);
    endtask

    task automatic test_free_from_full();
        drive(1, 1, 5, 0);
        #1;
        checks++;
        if (rst_out !== 8'h20 || tif.alloc_ready !== 1'b0 || set_out !== '0) begin
            errors++; $display("FAIL free_pulse rst_out=%h ready=%b set_out=%h want 20/0/00",
                               rst_out, tif.alloc_ready, set_out);
        end
        @(posedge CLK); model_edge();
        @(negedge CLK);
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (busy !== 8'hDF || cnt !== 4'd7 || tif.alloc_ready !== 1'b1 || tif.alloc_tag !== 3'd5 || full !== 1'b0) begin
            errors++; $display("FAIL free_after busy=%h cnt=%0d ready=%b tag=%0d full=%b want df/7/1/5/0",
                               busy, cnt, tif.alloc_ready, tif.alloc_tag, full);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, 0);
        drive(1, 1, 1, 0);
        #1;
        checks++;
        if (set_out !== 8'h10 || rst_out !== 8'h02) begin
            errors++; $display("FAIL b2b_pulses set_out=%h rst_out=%h want 10/02", set_out, rst_out);
        end
        @(posedge CLK); model_edge(); #1;
        checks++;
        if (busy !== 8'h1D || cnt !== 4'd4) begin
            errors++; $display("FAIL b2b_state busy=%h cnt=%0d want 1d/4", busy, cnt);
        end
        @(negedge CLK);
        drive(0, 0, 0, 0);
    endtask

    task automatic test_dblfree();
        do_reset();
        do_cycle(1, 0, 0, 0);
        do_cycle(1, 0, 0, 0);
        drive(0, 1, 6, 0);
        #1;
        checks++;
        if (rst_out !== '0) begin
            errors++; $display("FAIL dbl_pulse rst_out=%h want 00", rst_out);
        end
        @(posedge CLK); model_edge(); #1;
        checks++;
        if (busy !== 8'h03 || cnt !== 4'd2 || err_dblfree !== 1'b1) begin
            errors++; $display("FAIL dbl_state busy=%h cnt=%0d err=%b want 03/2/1", busy, cnt, err_dblfree);
        end
        @(negedge CLK);
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 0, 0);
        do_cycle(1, 1, 1, 0);
        #1;
        checks++;
        if (err_dblfree !== 1'b1) begin
            errors++; $display("FAIL dbl_sticky err=%b want 1", err_dblfree);
        end
        do_reset();
        #1;
        checks++;
        if (err_dblfree !== 1'b0) begin
            errors++; $display("FAIL dbl_clear err=%b want 0", err_dblfree);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < DW; i++) do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 1, 0);
        do_cycle(0, 1, 3, 0);
        do_cycle(0, 1, 4, 0);
        do_cycle(0, 1, 6, 0);
        drive(1, 1, 1, 1);
        #1;
        checks++;
        if (busy !== 8'hA5 || tif.alloc_ready !== 1'b0 || set_out !== '0 || rst_out !== 8'hA5) begin
            errors++; $display("FAIL flush_pulses busy=%h ready=%b set_out=%h rst_out=%h want a5/0/00/a5",
                               busy, tif.alloc_ready, set_out, rst_out);
        end
        @(posedge CLK); model_edge(); #1;
        checks++;
        if (busy !== '0 || cnt !== '0 || empty !== 1'b1 || err_dblfree !== 1'b0) begin
            errors++; $display("FAIL flush_state busy=%h cnt=%0d empty=%b err=%b want 00/0/1/0",
                               busy, cnt, empty, err_dblfree);
        end
        @(negedge CLK);
        drive(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int ft, t;
        bit av, fv, fl;
        logic [DW-1:0] exp_set, exp_rst;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            av = ($urandom_range(0, 99) < 55);
            fv = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 2);
            ft = $urandom_range(0, DW - 1);
            for (int k = 0; k < 8 && !mb[ft] && $urandom_range(0, 9) != 0; k++)
                ft = $urandom_range(0, DW - 1);
            RST = (cyc == 5000);
            drive(av, fv, ft, fl);
            #1;
            t = m_tag();
            exp_set = '0;
            exp_rst = '0;
            if (!RST) begin
                if (fl) exp_rst = m_vec();
                else begin
                    if (av && m_ready()) exp_set[t] = 1'b1;
                    if (fv && mb[ft]) exp_rst[ft] = 1'b1;
                end
            end
            checks++;
            if (set_out !== exp_set || rst_out !== exp_rst || tif.alloc_ready !== m_ready()) begin
                errors++; $display("FAIL rand_comb cyc=%0d set_out=%h/%h rst_out=%h/%h ready=%b/%b",
                                   cyc, set_out, exp_set, rst_out, exp_rst, tif.alloc_ready, m_ready());
            end
            if (mcnt != DW) begin
                checks++;
                if (int'(tif.alloc_tag) != t) begin
                    errors++; $display("FAIL rand_tag cyc=%0d tag=%0d want %0d", cyc, tif.alloc_tag, t);
                end
            end
            @(posedge CLK); model_edge(); #1;
            checks++;
            if (busy !== m_vec() || int'(cnt) != mcnt || full !== (mcnt == DW) ||
                empty !== (mcnt == 0) || err_dblfree !== merr) begin
                errors++; $display("FAIL rand_state cyc=%0d busy=%h/%h cnt=%0d/%0d full=%b empty=%b err=%b/%b",
                                   cyc, busy, m_vec(), cnt, mcnt, full, empty, err_dblfree, merr);
            end
            @(negedge CLK);
        end
        RST = 1'b0;
        drive(0, 0, 0, 0);
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 0, 0, 0);
        test_reset();
        inv_en = 1'b1;
        test_fill();
        test_free_from_full();
        test_back_to_back();
        test_dblfree();
        test_flush();
        test_random();
        inv_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
